// File: rtl/bus_lock_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_lock_queue_if
// Purpose  : Handshake/bus bundle for bus_lock_queue.
//            The producer pushes words with enable/inBus. The consumer reads
//            outBus/outValid and retires the head word with pop.
// Ports    : master - drives enable, inBus, pop; observes the queue outputs
//            slave  - the queue itself (receives requests, drives status)
// Revision : 1.0 - initial release
// ============================================================================
interface bus_lock_queue_if #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 4
);
  localparam int c_count_w = $clog2(DEPTH + 1);

  logic                 enable;
  logic [BUS_WIDTH-1:0] inBus;
  logic                 pop;
  logic [BUS_WIDTH-1:0] outBus;
  logic                 outValid;
  logic                 full;
  logic [c_count_w-1:0] count;
  logic                 overflow;

  modport master (
    output enable, inBus, pop,
    input  outBus, outValid, full, count, overflow
  );

  modport slave (
    input  enable, inBus, pop,
    output outBus, outValid, full, count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/bus_lock_queue.sv
`default_nettype none
// ============================================================================
// Module   : bus_lock_queue
// Purpose  : DEPTH-entry circular FIFO. It sits between RC4 datapath
//            producers and slower consumers. While empty, outBus holds the
//            last word consumed, so downstream logic keeps the old
//            single-register latch behaviour.
// Ports    : clk   - rising-edge clock
//            reset - synchronous active-high reset
//            bus   - bus_lock_queue_if.slave:
//                    enable/inBus push, pop consume, outBus/outValid head,
//                    full/count occupancy, overflow dropped-push pulse
// Revision : 1.0 - initial release
// ============================================================================
module bus_lock_queue #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  bus_lock_queue_if.slave  bus
);
  localparam int c_count_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w   = $clog2(DEPTH);

  logic [BUS_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_count_w-1:0] r_count;
  logic [BUS_WIDTH-1:0] r_last;
  logic                 r_overflow;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop_ok;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [c_ptr_w-1:0]   w_rd_next;
  logic [c_ptr_w-1:0]   w_wr_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_count_w'(DEPTH));

  // Popping an empty queue is ignored. This also means an empty queue with
  // enable and pop both high only pushes; there is no bypass path.
  assign w_pop_ok  = bus.pop && !w_empty;
  // When full, a same-cycle pop frees the slot that this push fills.
  assign w_push_ok = bus.enable && (!w_full || w_pop_ok);
  assign w_drop    = bus.enable && !w_push_ok;

  // The wrap is explicit because DEPTH need not be a power of two.
  assign w_rd_next = (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_next = (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  // Storage has no reset. Stale contents are never visible because outBus
  // shows r_last whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.inBus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_next;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_next;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= w_drop;
    end
  end

  // All outputs come from registered state only. There is no
  // combinational path from the inputs.
  assign bus.outValid = !w_empty;
  assign bus.outBus   = w_empty ? r_last : r_mem[r_rd_ptr];
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_bus_lock_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_lock_queue
// Purpose  : Self-checking bench for bus_lock_queue (BUS_WIDTH=8, DEPTH=4).
//            A queue-based reference model predicts every output each cycle.
//            Literal checks pin key values of that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_lock_queue;
  localparam int BW = 8;
  localparam int DP = 4;

  logic clk;
  logic reset;

  bus_lock_queue_if #(.BUS_WIDTH(BW), .DEPTH(DP)) bus ();

  bus_lock_queue #(.BUS_WIDTH(BW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an unbounded queue limited to DP entries by rule.
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_last;
  logic          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [BW-1:0] exp_bus;
    exp_bus = (mq.size() != 0) ? mq[0] : m_last;
    chk("outValid", 32'(bus.outValid), 32'(mq.size() != 0));
    chk("outBus",   32'(bus.outBus),   32'(exp_bus));
    chk("full",     32'(bus.full),     32'(mq.size() == DP));
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic model_step(input logic r, input logic en, input logic [BW-1:0] d, input logic p);
    bit pop_ok;
    bit push_ok;
    if (r) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
    end else begin
      pop_ok  = p && (mq.size() > 0);
      push_ok = en && ((mq.size() < DP) || pop_ok);
      m_ovf   = en && !push_ok;
      if (pop_ok)  m_last = mq.pop_front();
      if (push_ok) mq.push_back(d);
    end
  endtask

  // One clock cycle: drive the inputs, let the edge happen, advance the
  // model, then compare 1 ns after the edge.
  task automatic cyc(input logic r, input logic en, input logic [BW-1:0] d, input logic p);
    reset      = r;
    bus.enable = en;
    bus.inBus  = d;
    bus.pop    = p;
    @(posedge clk);
    model_step(r, en, d, p);
    #1;
    compare();
  endtask

  task automatic idle();  cyc(1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic push(input logic [BW-1:0] d); cyc(1'b0, 1'b1, d, 1'b0); endtask
  task automatic popw(); cyc(1'b0, 1'b0, 8'h00, 1'b1); endtask

  initial begin
    m_last = '0;
    m_ovf  = 1'b0;
    reset = 1'b1; bus.enable = 1'b0; bus.inBus = '0; bus.pop = 1'b0;

    // Reset, then three idle cycles.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_outBus", 32'(bus.outBus), 32'h00);
    chk("rst_count",  32'(bus.count),  32'd0);
    for (int i = 0; i < 3; i++) idle();

    // Fill, then overflow with 0x55.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_full",  32'(bus.full),  32'd1);
    push(8'h55);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    idle();
    chk("ovf_clear", 32'(bus.overflow), 32'd0);

    // Drain. The head is checked before each pop.
    chk("drain0", 32'(bus.outBus), 32'h11); popw();
    chk("drain1", 32'(bus.outBus), 32'h22); popw();
    chk("drain2", 32'(bus.outBus), 32'h33); popw();
    chk("drain3", 32'(bus.outBus), 32'h44); popw();
    chk("empty_hold", 32'(bus.outBus), 32'h44);
    chk("empty_valid", 32'(bus.outValid), 32'd0);
    popw();
    chk("extra_pop_count", 32'(bus.count), 32'd0);
    chk("extra_pop_bus",   32'(bus.outBus), 32'h44);

    // Push-one/pop-one across the pointer wrap.
    for (int i = 0; i < 6; i++) begin
      push(8'hA0 + 8'(i));
      chk("wrap_head", 32'(bus.outBus), 32'(8'hA0 + 8'(i)));
      chk("wrap_count", 32'(bus.count), 32'd1);
      popw();
    end
    chk("wrap_last", 32'(bus.outBus), 32'hA5);

    // Full, then push and pop 0x99 in the same cycle.
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    cyc(1'b0, 1'b1, 8'h99, 1'b1);
    chk("fullpp_count", 32'(bus.count), 32'd4);
    chk("fullpp_ovf",   32'(bus.overflow), 32'd0);
    chk("fullpp_head",  32'(bus.outBus), 32'hB1);
    popw(); popw(); popw();
    chk("fullpp_fourth", 32'(bus.outBus), 32'h99);
    popw();

    // Empty queue with enable and pop both high: push only, no bypass.
    cyc(1'b0, 1'b1, 8'h5A, 1'b1);
    chk("nobypass_count", 32'(bus.count), 32'd1);
    chk("nobypass_head",  32'(bus.outBus), 32'h5A);
    popw();

    // Reset with count=3 and enable/pop high.
    push(8'hC0); push(8'hC1); push(8'hC2);
    cyc(1'b1, 1'b1, 8'hC3, 1'b1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_bus",   32'(bus.outBus), 32'h00);
    chk("midrst_valid", 32'(bus.outValid), 32'd0);
    push(8'h7E);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_head",  32'(bus.outBus), 32'h7E);
    popw();
    chk("post_rst_alone", 32'(bus.count), 32'd0);
    chk("post_rst_last",  32'(bus.outBus), 32'h7E);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bus_lock_queue.md
Name: bus_lock_queue

Overview:
- Parametrised successor to the single-register bus latch.
- Captures `inBus` on each enabled cycle into a DEPTH-entry circular buffer. Presents the oldest captured word on `outBus` with a valid/pop handshake.
- When empty, `outBus` holds the last word consumed, preserving latch semantics for downstream consumers.
- Sits between RC4 datapath producers (keystream/S-box readers) and slower consumers. Decouples their timing.

Parameters:
- BUS_WIDTH, 8, width in bits of every stored word, `inBus` and `outBus`; legal range ≥1.
- DEPTH, 4, number of storage entries; legal range ≥2; need not be a power of two.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  push request: capture `inBus` this cycle.
- inBus  input  BUS_WIDTH  data to capture.
- pop  input  1  consume the word currently on `outBus`.
- outBus  output  BUS_WIDTH  head word when `outValid`; else last popped word.
- outValid  output  1  queue non-empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of stored words.
- overflow  output  1  one-cycle pulse: push dropped because queue full.

Behaviour:
- Reset (`reset`=1 at a rising edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - `last` register=0, `overflow`=0.
  - Storage contents undefined; never observable.
  - Reset has priority over `enable`/`pop` in the same cycle. Mid-operation reset discards all stored words.
- Reset values of outputs: `outBus`=0, `outValid`=0, `full`=0, `count`=0, `overflow`=0.
- Push accepted when `enable`=1 and (count<DEPTH, or count==DEPTH with pop accepted the same cycle).
  - Accepted push writes mem[wr_ptr]←inBus.
  - wr_ptr advances; wrap DEPTH-1→0 explicitly, not by truncation.
- Pop accepted when `pop`=1 and count>0.
  - Accepted pop copies mem[rd_ptr] into `last`.
  - rd_ptr advances with the same wrap rule.
  - Pop with count==0 is ignored; no state change.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous accepted push+pop, or on neither.
- Empty with `enable`=1 and `pop`=1: push accepted, pop ignored (no bypass). count becomes 1.
- Full with `enable`=1 and `pop`=0: push dropped, storage untouched. `overflow`=1 in the following cycle only.
- Full with `enable`=1 and `pop`=1: both accepted. count stays DEPTH, `overflow`=0.
- outBus and outValid are combinational from registered state:
  - `outValid` = (count≠0).
  - `outBus` = mem[rd_ptr] when `outValid`, else `last`.
- Latency: word pushed into an empty queue at edge N is on `outBus` with `outValid`=1 in the cycle after edge N.
- Ordering is strictly FIFO; no word is duplicated or reordered across pointer wrap.
- `full` and `count` are derived from the registered count; no glitch path from inputs.

Test Plan (BUS_WIDTH=8, DEPTH=4):
- Reset, then idle 3 cycles → `outBus`=0x00, `outValid`=0, `count`=0, `full`=0, `overflow`=0 throughout.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles, then push 0x55 → `full`=1, `count`=4; `overflow` pulses once after 0x55; popping 4 times yields 0x11,0x22,0x33,0x44.
- After those pops, `outValid`=0 and `outBus` stays 0x44. An extra `pop` leaves `count`=0 and `outBus`=0x44.
- Wrap: 6 rounds of push-one/pop-one with 0xA0..0xA5 → each word seen on `outBus` the cycle after its push; `count` never exceeds 1; pointers wrap 3→0 correctly.
- Full plus simultaneous `enable`/`pop` with 0x99 → head advances, `count` stays 4, `overflow`=0; 0x99 emerges fourth.
- Reset asserted with `count`=3 and `enable`/`pop` both high → next cycle `count`=0, `outValid`=0, `outBus`=0x00; a subsequent push of 0x7E appears alone.
